led_fade_pwm: RTL and testbench

//  Downstream stage of the 1 s LED blinker. Consumes the blinker's square-wave
//  LED level and drives the physical LED pin with a PWM signal whose brightness

---
 rtl/led_fade_pwm_if.sv | 30 +++
 rtl/led_fade_pwm.sv | 147 ++++++++++++++
 tb/tb_led_fade_pwm.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/led_fade_pwm_if.sv
// LED fade stage signal bundle: blinker level and mode in, PWM drive and status out.
// No latency of its own; it only groups wires.
// No backpressure: every signal is a plain level.
interface led_fade_pwm_if #(
  parameter int PWM_BITS = 8
);
  logic                led_in;
  logic                enable;
  logic                led_pwm;
  logic [PWM_BITS-1:0] level;
  logic                busy;

  // Upstream side: drives the blinker level and the mode, watches the LED drive.
  modport master (
    output led_in,
    output enable,
    input  led_pwm,
    input  level,
    input  busy
  );

  // Fade stage side.
  modport slave (
    input  led_in,
    input  enable,
    output led_pwm,
    output level,
    output busy
  );
endinterface

// File: rtl/led_fade_pwm.sv
// Breathing LED driver: ramps PWM brightness up/down following the blinker's level.
// Latency: level moves STEP_CYCLES clocks after a ramp starts; led_pwm is one clock behind level.
// No backpressure: led_in is sampled every clock and the outputs are always valid.
module led_fade_pwm #(
  parameter int PWM_BITS    = 8,
  parameter int STEP_CYCLES = 50_000
) (
  input  logic           clock,
  input  logic           reset_n,
  led_fade_pwm_if.slave  bus
);

  localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  localparam logic [PWM_BITS-1:0] LVL_MAX      = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] LVL_ONE      = PWM_BITS'(1);
  localparam logic [PWM_BITS-1:0] LVL_PWM_LAST = LVL_MAX - LVL_ONE;
  localparam logic [CNT_W-1:0]    STEP_LAST    = CNT_W'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_UP   = 2'd1,
    S_ON   = 2'd2,
    S_DOWN = 2'd3
  } state_t;

  state_t              r_state;
  logic [PWM_BITS-1:0] r_level;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [CNT_W-1:0]    r_step_cnt;
  logic                r_busy;
  logic                r_led_pwm;

  logic w_tick;

  // A brightness step is due when the step timer sits on its last count.
  assign w_tick = (r_step_cnt == STEP_LAST);

  // Reset release is expected to be synchronised upstream (board reset logic);
  // assertion clears everything immediately, aborting any ramp in flight.
  // Ramp state machine: level, step timer and busy all move together with state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_OFF;
      r_level    <= '0;
      r_step_cnt <= '0;
      r_busy     <= 1'b0;
    end else if (!bus.enable) begin
      // Bypass: snap straight to full on/off so a later enable resumes cleanly.
      r_state    <= bus.led_in ? S_ON : S_OFF;
      r_level    <= bus.led_in ? LVL_MAX : '0;
      r_step_cnt <= '0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        S_OFF: begin
          r_level    <= '0;
          r_step_cnt <= '0;
          if (bus.led_in) begin
            r_state <= S_UP;
            r_busy  <= 1'b1;
          end else begin
            r_busy  <= 1'b0;
          end
        end

        S_UP: begin
          if (!bus.led_in) begin
            // Reversal beats a coincident step: level holds, timer restarts.
            r_state    <= S_DOWN;
            r_step_cnt <= '0;
            r_busy     <= 1'b1;
          end else if (w_tick) begin
            r_step_cnt <= '0;
            if (r_level >= LVL_PWM_LAST) begin
              r_level <= LVL_MAX;
              r_state <= S_ON;
              r_busy  <= 1'b0;
            end else begin
              r_level <= r_level + LVL_ONE;
              r_busy  <= 1'b1;
            end
          end else begin
            r_step_cnt <= r_step_cnt + 1'b1;
            r_busy     <= 1'b1;
          end
        end

        S_ON: begin
          r_level    <= LVL_MAX;
          r_step_cnt <= '0;
          if (!bus.led_in) begin
            r_state <= S_DOWN;
            r_busy  <= 1'b1;
          end else begin
            r_busy  <= 1'b0;
          end
        end

        S_DOWN: begin
          if (bus.led_in) begin
            r_state    <= S_UP;
            r_step_cnt <= '0;
            r_busy     <= 1'b1;
          end else if (w_tick) begin
            r_step_cnt <= '0;
            // A reversal at level 0 can land here; saturate rather than wrap.
            if (r_level <= LVL_ONE) begin
              r_level <= '0;
              r_state <= S_OFF;
              r_busy  <= 1'b0;
            end else begin
              r_level <= r_level - LVL_ONE;
              r_busy  <= 1'b1;
            end
          end else begin
            r_step_cnt <= r_step_cnt + 1'b1;
            r_busy     <= 1'b1;
          end
        end

        default: begin
          r_state    <= S_OFF;
          r_level    <= '0;
          r_step_cnt <= '0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  // PWM: counter period is MAX clocks so level MAX gives a solid 1 and 0 a solid 0.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pwm_cnt <= '0;
      r_led_pwm <= 1'b0;
    end else begin
      r_pwm_cnt <= (r_pwm_cnt == LVL_PWM_LAST) ? '0 : r_pwm_cnt + LVL_ONE;
      r_led_pwm <= (r_pwm_cnt < r_level);
    end
  end

  assign bus.led_pwm = r_led_pwm;
  assign bus.level   = r_level;
  assign bus.busy    = r_busy;

endmodule

// File: tb/tb_led_fade_pwm.sv
// Bench for led_fade_pwm with MAX=15 and a 4-clock brightness step.
// Inputs change 1 ns after a rising edge; outputs are sampled at the same point.
module tb_led_fade_pwm;

  localparam int PB = 4;
  localparam int SC = 4;

  logic clock;
  logic reset_n;

  led_fade_pwm_if #(.PWM_BITS(PB)) bus();

  led_fade_pwm #(.PWM_BITS(PB), .STEP_CYCLES(SC)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  logic exp_q[$];
  int   lvl_q[$];

  initial clock = 1'b0;
  always #10 clock = ~clock;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_level(input logic [3:0] l, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus.level == l) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic hold_count(input bit toggle, output int hi);
    hi = 0;
    for (int i = 0; i < 17; i++) begin
      if (toggle) bus.led_in = ~bus.led_in;
      tick();
      if (i >= 2) hi += int'(bus.led_pwm);
    end
  endtask

  task automatic test_reset;
    reset_n    = 1'b1;
    bus.led_in = 1'b1;
    bus.enable = 1'b1;
    #5 reset_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.led_pwm, bus.busy, bus.level} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_async_initial: got %b expected 000000", {bus.led_pwm, bus.busy, bus.level});
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if ({bus.led_pwm, bus.busy, bus.level} !== 6'b0) begin
        n_fail++;
        $display("FAIL reset_hold cyc%0d: got %b expected 000000", i, {bus.led_pwm, bus.busy, bus.level});
      end
    end
    reset_n = 1'b1;
    tick();
    n_tests++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_then_ramp_busy: got %b expected 1", bus.busy);
    end
    #5 reset_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.led_pwm, bus.busy, bus.level} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_async_midcycle: got %b expected 000000", {bus.led_pwm, bus.busy, bus.level});
    end
    bus.led_in = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(2);
  endtask

  task automatic test_up_ramp;
    int lows;
    bus.led_in = 1'b1;
    tick();
    n_tests++;
    if (bus.busy !== 1'b1 || bus.level !== 4'd0) begin
      n_fail++;
      $display("FAIL up_entry: busy=%b level=%0d expected busy=1 level=0", bus.busy, bus.level);
    end
    tick(3);
    n_tests++;
    if (bus.level !== 4'd0) begin
      n_fail++;
      $display("FAIL up_before_step: level=%0d expected 0", bus.level);
    end
    tick();
    n_tests++;
    if (bus.level !== 4'd1) begin
      n_fail++;
      $display("FAIL up_first_step: level=%0d expected 1", bus.level);
    end
    tick(55);
    n_tests++;
    if (bus.level !== 4'd14 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL up_clk59: level=%0d busy=%b expected 14/1", bus.level, bus.busy);
    end
    tick();
    n_tests++;
    if (bus.level !== 4'd15 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL up_full_clk60: level=%0d busy=%b expected 15/0", bus.level, bus.busy);
    end
    tick();
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.led_pwm !== 1'b1) lows++;
    end
    n_tests++;
    if (lows !== 0 || bus.level !== 4'd15) begin
      n_fail++;
      $display("FAIL up_on_held: low_cycles=%0d level=%0d expected 0/15", lows, bus.level);
    end
  endtask

  task automatic test_duty;
    int hi;
    int exp_l;
    bit ok;
    int lv_list[3] = '{3, 7, 12};
    // full brightness from the previous ramp
    lvl_q.push_back(15);
    hold_count(1'b0, hi);
    exp_l = lvl_q.pop_front();
    n_tests++;
    if (hi !== exp_l) begin
      n_fail++;
      $display("FAIL duty_L15: high=%0d expected %0d", hi, exp_l);
    end
    bus.led_in = 1'b0;
    wait_level(4'd0, 200, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL duty_fall_timeout: level=%0d expected 0", bus.level);
    end
    tick();
    lvl_q.push_back(0);
    hold_count(1'b0, hi);
    exp_l = lvl_q.pop_front();
    n_tests++;
    if (hi !== exp_l) begin
      n_fail++;
      $display("FAIL duty_L0: high=%0d expected %0d", hi, exp_l);
    end
    foreach (lv_list[k]) begin
      bus.led_in = 1'b1;
      wait_level(4'(lv_list[k]), 200, ok);
      n_tests++;
      if (!ok) begin
        n_fail++;
        $display("FAIL duty_reach_L%0d: level=%0d expected %0d", lv_list[k], bus.level, lv_list[k]);
      end
      // Reversing every clock keeps the step timer from ever firing.
      lvl_q.push_back(lv_list[k]);
      hold_count(1'b1, hi);
      exp_l = lvl_q.pop_front();
      n_tests++;
      if (hi !== exp_l || int'(bus.level) !== exp_l) begin
        n_fail++;
        $display("FAIL duty_L%0d: high=%0d level=%0d expected %0d", lv_list[k], hi, bus.level, exp_l);
      end
    end
    bus.led_in = 1'b0;
    wait_level(4'd0, 300, ok);
    tick();
    n_tests++;
    if (!ok || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL duty_return_off: level=%0d busy=%b expected 0/0", bus.level, bus.busy);
    end
  endtask

  task automatic test_reversal;
    bit ok;
    bus.led_in = 1'b1;
    wait_level(4'd7, 100, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL rev_reach7: level=%0d expected 7", bus.level);
    end
    bus.led_in = 1'b0;
    tick(4);
    n_tests++;
    if (bus.level !== 4'd7 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rev_hold: level=%0d busy=%b expected 7/1", bus.level, bus.busy);
    end
    tick();
    n_tests++;
    if (bus.level !== 4'd6) begin
      n_fail++;
      $display("FAIL rev_first_down: level=%0d expected 6", bus.level);
    end
    tick(23);
    n_tests++;
    if (bus.level !== 4'd1 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rev_clk27: level=%0d busy=%b expected 1/1", bus.level, bus.busy);
    end
    tick();
    n_tests++;
    if (bus.level !== 4'd0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rev_off_clk28: level=%0d busy=%b expected 0/0", bus.level, bus.busy);
    end
    // reversal landing on the step-tick edge
    bus.led_in = 1'b1;
    wait_level(4'd7, 100, ok);
    tick(3);
    bus.led_in = 1'b0;
    tick();
    n_tests++;
    if (!ok || bus.level !== 4'd7 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rev_on_tick: level=%0d busy=%b expected 7/1", bus.level, bus.busy);
    end
    tick(3);
    n_tests++;
    if (bus.level !== 4'd7) begin
      n_fail++;
      $display("FAIL rev_on_tick_restart: level=%0d expected 7", bus.level);
    end
    tick();
    n_tests++;
    if (bus.level !== 4'd6) begin
      n_fail++;
      $display("FAIL rev_on_tick_step: level=%0d expected 6", bus.level);
    end
    wait_level(4'd0, 100, ok);
    tick();
  endtask

  task automatic test_bypass;
    logic e;
    int   bad_status;
    exp_q.delete();
    bad_status = 0;
    bus.enable = 1'b0;
    for (int c = 0; c < 70; c++) begin
      if (exp_q.size() == 2) begin
        e = exp_q.pop_front();
        n_tests++;
        if (bus.led_pwm !== e) begin
          n_fail++;
          $display("FAIL bypass_follow c%0d: led_pwm=%b expected %b", c, bus.led_pwm, e);
        end
      end
      if (bus.busy !== 1'b0 || (bus.level !== 4'd0 && bus.level !== 4'd15)) bad_status++;
      bus.led_in = ((c / 10) % 2 == 0);
      exp_q.push_back(bus.led_in);
      tick();
    end
    n_tests++;
    if (bad_status !== 0) begin
      n_fail++;
      $display("FAIL bypass_status: bad_cycles=%0d expected 0", bad_status);
    end
    // back into fade mode while the blinker is high: must stay solidly on
    bus.enable = 1'b1;
    bad_status = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.led_pwm !== 1'b1 || bus.busy !== 1'b0 || bus.level !== 4'd15) bad_status++;
    end
    n_tests++;
    if (bad_status !== 0) begin
      n_fail++;
      $display("FAIL bypass_resume: bad_cycles=%0d expected 0", bad_status);
    end
  endtask

  task automatic test_reset_mid_fade;
    bit ok;
    bus.led_in = 1'b0;
    wait_level(4'd9, 100, ok);
    n_tests++;
    if (!ok || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_reach9: level=%0d busy=%b expected 9/1", bus.level, bus.busy);
    end
    #2 reset_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.led_pwm, bus.busy, bus.level} !== 6'b0) begin
      n_fail++;
      $display("FAIL midreset_async: got %b expected 000000", {bus.led_pwm, bus.busy, bus.level});
    end
    bus.led_in = 1'b1;
    tick(2);
    n_tests++;
    if ({bus.led_pwm, bus.busy, bus.level} !== 6'b0) begin
      n_fail++;
      $display("FAIL midreset_hold: got %b expected 000000", {bus.led_pwm, bus.busy, bus.level});
    end
    reset_n = 1'b1;
    tick();
    n_tests++;
    if (bus.busy !== 1'b1 || bus.level !== 4'd0) begin
      n_fail++;
      $display("FAIL midreset_fresh_entry: busy=%b level=%0d expected 1/0", bus.busy, bus.level);
    end
    tick(3);
    n_tests++;
    if (bus.level !== 4'd0) begin
      n_fail++;
      $display("FAIL midreset_fresh_wait: level=%0d expected 0", bus.level);
    end
    tick();
    n_tests++;
    if (bus.level !== 4'd1) begin
      n_fail++;
      $display("FAIL midreset_fresh_step: level=%0d expected 1", bus.level);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b1;
    bus.led_in = 1'b0;
    bus.enable = 1'b1;
    test_reset();
    test_up_ramp();
    test_duty();
    test_reversal();
    test_bypass();
    test_reset_mid_fade();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
